// File: rtl/hazard_flow_ctrl.sv
// ============================================================================
// hazard_flow_ctrl : pipeline stall/flush controller for the 5-stage core.
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_flow_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_dREN,
  input  logic             exmem_dWEN,
  input  logic             idex_dREN,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ctrl_redirect,
  input  logic             memwb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DWAIT = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             pend_flush_q, pend_flush_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic dmiss;
  logic lu;

  assign dmiss = (exmem_dREN | exmem_dWEN) & ~dhit;
  assign lu    = idex_dREN & (idex_rt != '0) &
                 ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

  always_comb begin
    state_d      = state_q;
    pend_flush_d = pend_flush_q;
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmem_en     = 1'b0;
    memwb_en     = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    memwb_flush  = 1'b0;

    if (state_q != S_HALT) begin
      if (memwb_halt) begin
        state_d = S_HALT;
      end else if (dmiss) begin
        // A redirect seen while frozen is remembered and replayed on release.
        state_d = S_DWAIT;
        if (ctrl_redirect) pend_flush_d = 1'b1;
      end else begin
        state_d  = S_RUN;
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
        if (ctrl_redirect | pend_flush_q) begin
          ifid_flush   = 1'b1;
          idex_flush   = 1'b1;
          pend_flush_d = 1'b0;
        end else if (lu) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end else if (!ihit) begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
        end
      end
    end

    if (!nRST) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
    end

    stall_cycles_d = stall_cycles_q;
    if (!pc_en && (state_q != S_HALT) && (stall_cycles_q != {CNT_W{1'b1}}))
      stall_cycles_d = stall_cycles_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q        <= S_RUN;
      pend_flush_q   <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      pend_flush_q   <= pend_flush_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign halted       = (state_q == S_HALT);
  assign stall_cycles = stall_cycles_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_flow_ctrl.sv
// ============================================================================
// tb_hazard_flow_ctrl : directed + randomized check against a behavioural model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hazard_flow_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 6;   // narrow counter so saturation is reachable
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             CLK = 1'b0;
  logic             nRST;
  logic             ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN;
  logic [REG_W-1:0] idex_rt, ifid_rs, ifid_rt;
  logic             ctrl_redirect, memwb_halt;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;

  hazard_flow_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN), .idex_dREN(idex_dREN),
    .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ctrl_redirect(ctrl_redirect), .memwb_halt(memwb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .halted(halted), .stall_cycles(stall_cycles)
  );

  always #5 CLK = ~CLK;

  // {pc, ifid, idex, exmem, memwb enables, ifid, idex, exmem, memwb flushes}
  wire [8:0] outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                     ifid_flush, idex_flush, exmem_flush, memwb_flush};

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit          m_halted;
  bit          m_pend;
  int unsigned m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] model_outs();
    bit dmiss, lu;
    dmiss = (exmem_dREN || exmem_dWEN) && !dhit;
    lu    = idex_dREN && (idex_rt != 0) && (idex_rt == ifid_rs || idex_rt == ifid_rt);
    if (m_halted || memwb_halt || dmiss) return 9'b00000_0000;
    if (ctrl_redirect || m_pend)         return 9'b11111_1100;
    if (lu)                              return 9'b00111_0100;
    if (!ihit)                           return 9'b01111_1000;
    return 9'b11111_0000;
  endfunction

  task automatic model_reset();
    m_halted = 0;
    m_pend   = 0;
    m_cnt    = 0;
  endtask

  task automatic set_idle();
    ihit = 1; dhit = 1; exmem_dREN = 0; exmem_dWEN = 0; idex_dREN = 0;
    idex_rt = '0; ifid_rs = '0; ifid_rt = '0; ctrl_redirect = 0; memwb_halt = 0;
  endtask

  // Entered just after a rising edge with inputs already applied.
  task automatic step();
    logic [8:0] e;
    bit dmiss;
    #3;
    e = model_outs();
    chk("outs", {23'd0, outs}, {23'd0, e});
    chk("halted", {31'd0, halted}, {31'd0, m_halted});
    chk("stall_cycles", {26'd0, stall_cycles}, m_cnt);
    @(posedge CLK);
    if (!m_halted) begin
      dmiss = (exmem_dREN || exmem_dWEN) && !dhit;
      if (!e[8] && m_cnt < CNT_MAX) m_cnt++;
      if (memwb_halt)                   m_halted = 1;
      else if (dmiss)                   begin if (ctrl_redirect) m_pend = 1; end
      else if (ctrl_redirect || m_pend) m_pend = 0;
    end
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle; effects must be immediate.
  task automatic do_reset();
    #2;
    nRST = 0;
    #1;
    chk("rst_outs", {23'd0, outs}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_stall", {26'd0, stall_cycles}, 32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    nRST = 1;
  endtask

  initial begin
    int halt_age;
    nRST = 0;
    set_idle();
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("init_outs", {23'd0, outs}, 32'd0);
    chk("init_stall", {26'd0, stall_cycles}, 32'd0);
    nRST = 1;

    // Load-use on rs
    idex_dREN = 1; idex_rt = 5'd5; ifid_rs = 5'd5; ifid_rt = 5'd7;
    step();
    idex_dREN = 0;
    step();
    chk("lu_stall_count", {26'd0, stall_cycles}, 32'd1);

    // Register 0 load never stalls
    idex_dREN = 1; idex_rt = '0; ifid_rs = 5'd3; ifid_rt = '0;
    step();
    chk("r0_no_stall", {26'd0, stall_cycles}, 32'd1);
    set_idle();

    // Data-memory wait with redirect in second frozen cycle
    do_reset();
    exmem_dREN = 1; dhit = 0;
    step();
    ctrl_redirect = 1; step();
    ctrl_redirect = 0; step();
    dhit = 1; step();            // pending flush replays here
    exmem_dREN = 0; step();
    chk("dwait_stall_count", {26'd0, stall_cycles}, 32'd3);

    // Fetch miss, then redirect during the miss
    ihit = 0; step(); step();
    ctrl_redirect = 1; step();
    ctrl_redirect = 0; ihit = 1; step();

    // Halt: sticky, counter bumps once on entry
    do_reset();
    memwb_halt = 1; step();
    memwb_halt = 0;
    for (int i = 0; i < 6; i++) begin
      ihit = i[0]; dhit = i[1]; ctrl_redirect = ~i[0]; exmem_dREN = i[2];
      step();
    end
    chk("halt_sticky", {31'd0, halted}, 32'd1);
    chk("halt_stall_count", {26'd0, stall_cycles}, 32'd1);
    do_reset();
    set_idle();

    // Saturation: a long fetch miss runs the counter past all-ones
    ihit = 0;
    for (int i = 0; i < int'(CNT_MAX) + 4; i++) step();
    chk("stall_saturated", {26'd0, stall_cycles}, {26'd0, CNT_MAX});
    ihit = 1; step();

    // Randomized traffic
    do_reset();
    halt_age = 0;
    for (int i = 0; i < 3000; i++) begin
      ihit          = ($urandom_range(0, 3) != 0);
      dhit          = ($urandom_range(0, 2) != 0);
      exmem_dREN    = ($urandom_range(0, 3) == 0);
      exmem_dWEN    = ($urandom_range(0, 3) == 0);
      idex_dREN     = $urandom_range(0, 1);
      idex_rt       = REG_W'($urandom_range(0, 3));
      ifid_rs       = REG_W'($urandom_range(0, 3));
      ifid_rt       = REG_W'($urandom_range(0, 3));
      ctrl_redirect = ($urandom_range(0, 5) == 0);
      memwb_halt    = ($urandom_range(0, 99) == 0);
      halt_age      = m_halted ? halt_age + 1 : 0;
      if (halt_age > 8 || $urandom_range(0, 199) == 0) begin
        do_reset();
        halt_age = 0;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
